// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID register: PC sequencing, ready-handshake imem requests, redirects, stall/flush.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'hE000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic [31:0] instr_q, instr_d, pc8_q, pc8_d;
    logic        valid_q, valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d, skid_pc8_q, skid_pc8_d;
    logic        discard_q, discard_d;
    logic        redirect, req, accept_good;
    logic [31:0] redirect_pc, addr;

    always_comb begin
        redirect    = BranchTakenE | PCSrcW;
        redirect_pc = (BranchTakenE ? ALUResultE : ResultW) & ~32'h3;
        req         = 1'b0;
        addr        = pc_q;
        accept_good = 1'b0;
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        case (state_q)
            S_FETCH: begin
                req = ~StallF & ~StallD & ~redirect & ~skid_valid_q & ~discard_q;
                if (req) begin
                    req_addr_d = pc_q;
                    if (imem_ready) accept_good = 1'b1;
                    else            state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                req  = 1'b1;
                addr = req_addr_q;
                if (imem_ready) begin
                    state_d     = S_FETCH;
                    accept_good = ~redirect;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                req  = 1'b1;
                addr = req_addr_q;
                if (imem_ready) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (reset) req = 1'b0;

        if (redirect)         pc_d = redirect_pc;
        else if (accept_good) pc_d = pc_q + 32'd4;
        else                  pc_d = pc_q;

        // A reset that lands while a response is still owed must swallow that late response.
        discard_d = reset & ((state_q != S_FETCH) | discard_q) & ~imem_ready;
    end

    always_comb begin
        instr_d      = instr_q;
        pc8_d        = pc8_q;
        valid_d      = valid_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc8_d   = skid_pc8_q;
        if (FlushD) begin
            instr_d      = BUBBLE_INSTR;
            pc8_d        = '0;
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (StallD) begin
            // Only a WAIT completion can arrive under StallD; park it until Decode frees up.
            if (redirect) begin
                skid_valid_d = 1'b0;
            end else if (accept_good) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc8_d   = addr + 32'd8;
            end
        end else if (skid_valid_q && !redirect) begin
            instr_d      = skid_instr_q;
            pc8_d        = skid_pc8_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept_good) begin
            instr_d = imem_rdata;
            pc8_d   = addr + 32'd8;
            valid_d = 1'b1;
        end else begin
            instr_d      = BUBBLE_INSTR;
            pc8_d        = '0;
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        discard_q <= discard_d;
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC & ~32'h3;
            req_addr_q   <= RESET_PC & ~32'h3;
            instr_q      <= BUBBLE_INSTR;
            pc8_q        <= '0;
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc8_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            instr_q      <= instr_d;
            pc8_q        <= pc8_d;
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc8_q   <= skid_pc8_d;
        end
    end

    assign imem_req  = req;
    assign imem_addr = addr & ~32'h3;
    assign PCF       = pc_q;
    assign InstrD    = instr_q;
    assign PCPlus8D  = pc8_q;
    assign ValidD    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, ~FlushD & ~StallD & valid_d};
        bubble_cnt_d = bubble_cnt_q + {31'd0, FlushD | (~StallD & ~valid_d)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign BubbleCount = bubble_cnt_q;
`else
    assign FetchCount  = '0;
    assign BubbleCount = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table plus randomized program-order scoreboard.
module tb_fetch_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, StallF, StallD, FlushD, BranchTakenE, PCSrcW, imem_ready;
    logic [31:0] ALUResultE, ResultW, imem_rdata;
    logic        imem_req, ValidD;
    logic [31:0] imem_addr, PCF, InstrD, PCPlus8D, FetchCount, BubbleCount;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] BUBBLE = 32'hE000_0000;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUBBLE_INSTR(BUBBLE)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW), .ResultW(ResultW),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
        .FetchCount(FetchCount), .BubbleCount(BubbleCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, sf, sd, fd, bt, pw, rdy;
        logic [31:0] alu, res;
        logic        ereq;
        logic [31:0] eaddr, epc;
        logic        ev;
        logic [31:0] epc8;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst, input logic sf, input logic sd, input logic fd,
                       input logic bt, input logic [31:0] alu, input logic pw, input logic [31:0] res,
                       input logic rdy, input logic ereq, input logic [31:0] eaddr,
                       input logic [31:0] epc, input logic ev, input logic [31:0] epc8);
        vec_t r;
        r.rst = rst; r.sf = sf; r.sd = sd; r.fd = fd; r.bt = bt; r.alu = alu; r.pw = pw;
        r.res = res; r.rdy = rdy; r.ereq = ereq; r.eaddr = eaddr; r.epc = epc; r.ev = ev; r.epc8 = epc8;
        vt.push_back(r);
    endtask

    task automatic drive_idle();
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; PCSrcW = 1'b0; ALUResultE = '0; ResultW = '0; imem_ready = 1'b1;
    endtask

    logic [31:0] fmodel, bmodel, exp_next, accepts, hold_addr;
    logic        hold, sd;

    initial begin
        drive_idle();
        //   rst sf sd fd bt alu           pw res           rdy req addr          pc            v  pc8
        add(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        32'h0,        0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h0,        32'h4,        1, 32'h8);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h4,        32'h8,        1, 32'hC);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h8,        32'hC,        1, 32'h10);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'hC,        32'h10,       1, 32'h14);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h10,       32'h10,       0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h10,       32'h10,       0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h10,       32'h10,       0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h10,       32'h14,       1, 32'h18);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h14,       32'h18,       1, 32'h1C);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h18,       32'h1C,       1, 32'h20);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h1C,       32'h20,       1, 32'h24);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h20,       32'h20,       0, 32'h0);
        add(0, 0, 0, 0, 1, 32'h100,      0, 32'h0,        0,  1, 32'h20,       32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h20,       32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h20,       32'h100,      0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h100,      32'h104,      1, 32'h108);
        add(0, 0, 0, 0, 1, 32'h200,      1, 32'h300,      1,  0, 32'h0,        32'h200,      0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h200,      32'h204,      1, 32'h208);
        add(0, 1, 1, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        32'h204,      1, 32'h208);
        add(0, 1, 1, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        32'h204,      1, 32'h208);
        add(0, 1, 1, 1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        32'h204,      0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h204,      32'h208,      1, 32'h20C);
        add(0, 0, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFE, 1,  0, 32'h0,        32'hFFFFFFFC, 0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'hFFFFFFFC, 32'h0,        1, 32'h4);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h0,        32'h4,        1, 32'h8);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h4,        32'h4,        0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h4,        32'h8,        0, 32'h0);
        add(0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        32'h8,        0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        32'h8,        1, 32'hC);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h8,        32'hC,        1, 32'h10);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'hC,        32'hC,        0, 32'h0);
        add(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        32'h0,        0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        32'h0,        0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h0,        32'h4,        1, 32'h8);
        add(0, 1, 0, 0, 1, 32'h40,       0, 32'h0,        1,  0, 32'h0,        32'h40,       0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1,  1, 32'h40,       32'h44,       1, 32'h48);

        fmodel = '0;
        bmodel = '0;
        foreach (vt[i]) begin
            reset = vt[i].rst; StallF = vt[i].sf; StallD = vt[i].sd; FlushD = vt[i].fd;
            BranchTakenE = vt[i].bt; ALUResultE = vt[i].alu; PCSrcW = vt[i].pw; ResultW = vt[i].res;
            imem_ready = vt[i].rdy;
            #1;
            chk($sformatf("row%0d req", i), {31'd0, imem_req}, {31'd0, vt[i].ereq});
            if (vt[i].ereq) chk($sformatf("row%0d addr", i), imem_addr, vt[i].eaddr);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d pcf", i), PCF, vt[i].epc);
            chk($sformatf("row%0d validd", i), {31'd0, ValidD}, {31'd0, vt[i].ev});
            chk($sformatf("row%0d pc8", i), PCPlus8D, vt[i].epc8);
            chk($sformatf("row%0d instr", i), InstrD, vt[i].ev ? mem(vt[i].epc8 - 32'd8) : BUBBLE);
            if (vt[i].rst) begin
                fmodel = '0;
                bmodel = '0;
            end else begin
                if (!vt[i].fd && !vt[i].sd && vt[i].ev) fmodel++;
                if (vt[i].fd || (!vt[i].sd && !vt[i].ev)) bmodel++;
            end
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("row%0d fetchcnt", i), FetchCount, fmodel);
            chk($sformatf("row%0d bubblecnt", i), BubbleCount, bmodel);
            if (i == 8) chk("bubbles after 3 wait cycles", BubbleCount, 32'd3);
`else
            chk($sformatf("row%0d fetchcnt", i), FetchCount, 32'd0);
            chk($sformatf("row%0d bubblecnt", i), BubbleCount, 32'd0);
`endif
        end

        // Random ready/stall traffic: Decode must see the exact sequential program stream.
        drive_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_next = '0; accepts = '0; fmodel = '0; bmodel = '0; hold = 1'b0; hold_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            StallF     = ($urandom_range(0, 4) == 0);
            StallD     = ($urandom_range(0, 4) == 0);
            imem_ready = ($urandom_range(0, 2) != 0);
            if (c >= 2980) begin
                StallF = 1'b1; StallD = 1'b0; imem_ready = 1'b1;
            end
            #1;
            if (hold) begin
                chk("rand held req", {31'd0, imem_req}, 32'd1);
                chk("rand held addr", imem_addr, hold_addr);
            end
            hold      = imem_req & ~imem_ready;
            hold_addr = imem_addr;
            if (imem_req && imem_ready) accepts++;
            sd = StallD;
            @(posedge clk);
            #1;
            if (!sd) begin
                if (ValidD) begin
                    chk("rand pc8", PCPlus8D, exp_next + 32'd8);
                    chk("rand instr", InstrD, mem(exp_next));
                    exp_next += 32'd4;
                    fmodel++;
                end else begin
                    bmodel++;
                end
            end
        end
        chk("rand delivered count", fmodel, accepts);
        chk("rand final pcf", PCF, accepts << 2);
`ifdef FETCH_PERF_CNT_EN
        chk("rand fetchcnt", FetchCount, fmodel);
        chk("rand bubblecnt", BubbleCount, bmodel);
`else
        chk("rand fetchcnt", FetchCount, 32'd0);
        chk("rand bubblecnt", BubbleCount, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage and IF/ID pipeline register of the pipelined ARM core, directly upstream of the decode/control unit.
- Holds the PC and sequences instruction-memory requests over a ready handshake.
- Applies redirects from branch (Execute) and PC-write (Writeback), and delivers InstrD and PCPlus8D to Decode.
- Honours StallF/StallD/FlushD from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUBBLE_INSTR, 32'hE000_0000, instruction injected into Decode on flush/bubble (AND R0,R0,R0, always; architecturally neutral).

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- StallF  input  1  hold PC, issue no new request.
- StallD  input  1  hold IF/ID register.
- FlushD  input  1  load bubble into IF/ID register.
- BranchTakenE  input  1  branch redirect from Execute.
- ALUResultE  input  32  branch target.
- PCSrcW  input  1  PC-write redirect from Writeback.
- ResultW  input  32  PC-write target.
- imem_req  output  1  request valid.
- imem_addr  output  32  word address; stable while imem_req high until imem_ready.
- imem_ready  input  1  response valid this cycle.
- imem_rdata  input  32  instruction word, valid with imem_ready.
- PCF  output  32  current fetch PC.
- InstrD  output  32  instruction to Decode.
- PCPlus8D  output  32  PC+8 of InstrD (ARM R15 read value).
- ValidD  output  1  InstrD is a real fetched instruction.
- FetchCount  output  32  perf counter (see Optional Feature).
- BubbleCount  output  32  perf counter (see Optional Feature).

Behaviour:
- Reset (sync, high):
  - PCF=RESET_PC, state=FETCH, imem_req=0 during the reset cycle.
  - InstrD=BUBBLE_INSTR, PCPlus8D=0, ValidD=0, counters=0.
- Next-PC priority: BranchTakenE→ALUResultE; else PCSrcW→ResultW; else PCF+4 on an accepted fetch; else hold.
- A redirect always loads PCF, even with StallF high.
- All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. imem_addr[1:0] is always 00 (targets are word-aligned; bits[1:0] of a target are forced to 0).
- States:
  - FETCH: imem_req = ~StallF & ~StallD & ~redirect. imem_addr=PCF, latched into req_addr when imem_req is high.
    - Accept (req & ready) → PC advances; stay in FETCH (zero-wait fetch, one instruction per cycle).
    - Req & ~ready → WAIT.
  - WAIT: imem_req=1, imem_addr=req_addr; StallF/StallD are ignored for the request.
    - ready & no redirect → accept, PC advances → FETCH.
    - Redirect & ~ready → DROP.
    - Redirect & ready → response discarded → FETCH.
  - DROP: imem_req=1, imem_addr=req_addr (stale address). On ready the response is discarded → FETCH at the redirected PCF.
- IF/ID register priority: reset > FlushD > StallD > load.
  - Load value: {imem_rdata, req_addr+8, 1} on a non-discarded accept.
  - Otherwise load {BUBBLE_INSTR, 0, 0}.
- An accept coinciding with a redirect is never written to Decode.
- Latency: request cycle N with ready → InstrD valid at cycle N+1.
- A held request in WAIT that completes while StallD=1: instruction is parked in a one-entry skid buffer and loaded when StallD drops. PC still advances. Buffer full blocks new requests. A flush or redirect clears the buffer.
- Reset mid-WAIT/DROP: state returns to FETCH. The outstanding response arriving after reset is ignored (one-cycle discard flag set by reset while imem_ready is still pending).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - FetchCount increments on every accept written to Decode.
  - BubbleCount increments on every cycle a bubble is loaded into IF/ID.
  - Both counters wrap at 2^32.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Reset, then imem_ready=1 constantly with sequential words → PCF 0,4,8,…; InstrD follows one cycle later; PCPlus8D=8,12,16; ValidD=1 from cycle 2.
- imem_ready low 3 cycles at PCF=0x10 → imem_addr held at 0x10; three bubbles (ValidD=0); PCF=0x14 after the ready cycle; BubbleCount=3.
- BranchTakenE=1, ALUResultE=0x100 while in WAIT at 0x20 → DROP; response for 0x20 discarded; next request at 0x100; no 0x20 instruction reaches InstrD.
- BranchTakenE=1 (0x200) and PCSrcW=1 (0x300) in the same cycle → PCF=0x200.
- StallF=StallD=1 for 2 cycles in FETCH → imem_req=0, PCF and InstrD held; FlushD with StallD=1 → InstrD=0xE000_0000, ValidD=0.
- Redirect to 0xFFFF_FFFC → next sequential fetch at 0x0000_0000.
